// File: rtl/inst_fetch_mem_if.sv
// Fetch-stage bus between the core and the instruction memory.
interface inst_fetch_mem_if #(
    parameter int ADDR_W = 12,
    parameter int CU_W   = 5,
    parameter int DP_W   = 14
);
    localparam int INS_W = CU_W + DP_W;

    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              flush;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [INS_W-1:0]  prog_data;
    logic              ins_valid;
    logic [CU_W-1:0]   cu_out;
    logic [DP_W-1:0]   dp_out;
    logic              halt;
    logic              halted;

    modport master (
        output pc, fetch_en, flush, prog_we, prog_addr, prog_data,
        input  ins_valid, cu_out, dp_out, halt, halted
    );

    modport slave (
        input  pc, fetch_en, flush, prog_we, prog_addr, prog_data,
        output ins_valid, cu_out, dp_out, halt, halted
    );
endinterface

// File: rtl/inst_fetch_mem.sv
// Registered instruction memory for fetch: word split into cu/dp fields, sticky halt on all-zero word.
// Latency 1 cycle for reads and writes; IMEM_WR_FWD_EN enables write-to-read forwarding on collision.
// fetch_en=0 stalls (outputs hold), flush inserts a bubble, halted freezes the output register.
module inst_fetch_mem #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int CU_W   = 5,
    parameter int DP_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_mem_if.slave   bus
);
    localparam int INS_W = CU_W + DP_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [INS_W-1:0] mem [DEPTH];

    logic             rd_in_range;
    logic             wr_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [INS_W-1:0] mem_word;
    logic [INS_W-1:0] rd_word;

    logic             ins_valid_q;
    logic [INS_W-1:0] word_q;
    logic             halt_q;
    logic             halted_q;

    assign rd_in_range = ({1'b0, bus.pc} < DEPTH_X);
    assign wr_ok       = bus.prog_we && ({1'b0, bus.prog_addr} < DEPTH_X);
    assign rd_idx      = bus.pc[IDX_W-1:0];
    assign wr_idx      = bus.prog_addr[IDX_W-1:0];

    // Out-of-range addresses read as zero so they decode as halt.
    assign mem_word = rd_in_range ? mem[rd_idx] : '0;

`ifdef IMEM_WR_FWD_EN
    logic fwd_hit;
    assign fwd_hit = wr_ok && (bus.prog_addr == bus.pc);
    assign rd_word = fwd_hit ? bus.prog_data : mem_word;
`else
    assign rd_word = mem_word;
`endif

    // Program storage deliberately has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_valid_q <= 1'b0;
            word_q      <= '0;
            halt_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            halt_q <= 1'b0;
            if (halted_q) begin
                ins_valid_q <= 1'b0;
            end else if (bus.flush) begin
                ins_valid_q <= 1'b0;
                word_q      <= '0;
            end else if (bus.fetch_en) begin
                ins_valid_q <= 1'b1;
                word_q      <= rd_word;
                // halt is registered alongside the word it describes.
                if (rd_word == '0) begin
                    halt_q   <= 1'b1;
                    halted_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ins_valid = ins_valid_q;
    assign bus.cu_out    = word_q[INS_W-1:DP_W];
    assign bus.dp_out    = word_q[DP_W-1:0];
    assign bus.halt      = halt_q;
    assign bus.halted    = halted_q;
endmodule
